weight_bram_sequencer: RTL and testbench

- Controller that owns one 16-bit weight BRAM: DEPTH words, negedge-clocked, read-first-else-write port with ADDR/DI/EN/WE/DO.
- Two jobs, selected per operation:
  - LOAD: writes a stream of DEPTH weights into the BRAM.
  - READ: streams all DEPTH weights, in address order, to the neuron MAC over a valid/ready interface.
- Sits between the network weight loader / layer controller and each neuron's weight memory.

---
 rtl/weight_bram_sequencer.sv | 128 ++++++++++++
 tb/tb_weight_bram_sequencer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/weight_bram_sequencer.sv
// rtl/weight_bram_sequencer.sv - weight BRAM load/stream controller
// Owns one negedge BRAM; LOAD writes DEPTH words, READ streams them through a 2-entry credit FIFO.
module weight_bram_sequencer #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          MODE,
  output logic          BUSY,
  output logic          DONE,
  input  logic [DW-1:0] LD_DATA,
  input  logic          LD_VALID,
  output logic          LD_READY,
  output logic [DW-1:0] W_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic          W_LAST,
  output logic [AW-1:0] BRAM_ADDR,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  output logic [DW-1:0] BRAM_DI,
  input  logic [DW-1:0] BRAM_DO
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_FIN} state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_LAST  = (AW+1)'(DEPTH - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW:0]   r_count;
  logic          r_pend;
  logic          r_pend_last;
  logic [DW-1:0] r_fifo_data [2];
  logic [1:0]    r_fifo_last;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_occ;

  logic          w_pop;
  logic          w_issue;
  logic          w_ld_beat;

  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_issue   = 1'b0;
    w_ld_beat = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (START) w_next = MODE ? S_LOAD : S_READ;
      end
      S_LOAD: begin
        w_ld_beat = LD_VALID;
        if (LD_VALID && (r_count == LP_LAST)) w_next = S_FIN;
      end
      S_READ: begin
        w_pop   = (r_occ != 2'd0) && W_READY;
        // A read now lands in the FIFO next cycle, so reserve its slot against occupancy after this pop.
        w_issue = (r_count < LP_DEPTH) &&
                  (({1'b0, r_occ} + {2'b00, r_pend} - {2'b00, w_pop}) < 3'd2);
        if ((r_count == LP_DEPTH) && !r_pend && (r_occ == {1'b0, w_pop})) w_next = S_FIN;
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state        <= S_IDLE;
      r_count        <= '0;
      r_pend         <= 1'b0;
      r_pend_last    <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_occ          <= '0;
      BRAM_ADDR      <= '0;
      BRAM_EN        <= 1'b0;
      BRAM_WE        <= 1'b0;
      BRAM_DI        <= '0;
    end else begin
      r_state <= w_next;
      BRAM_EN <= 1'b0;
      BRAM_WE <= 1'b0;
      r_pend  <= w_issue;
      if ((r_state == S_IDLE) && START) r_count <= '0;
      if (w_ld_beat) begin
        BRAM_EN   <= 1'b1;
        BRAM_WE   <= 1'b1;
        BRAM_ADDR <= r_count[AW-1:0];
        BRAM_DI   <= LD_DATA;
        r_count   <= r_count + 1'b1;
      end
      if (w_issue) begin
        BRAM_EN     <= 1'b1;
        BRAM_ADDR   <= r_count[AW-1:0];
        r_pend_last <= (r_count == LP_LAST);
        r_count     <= r_count + 1'b1;
      end
      if (r_pend) begin
        r_fifo_data[r_wr_ptr] <= BRAM_DO;
        r_fifo_last[r_wr_ptr] <= r_pend_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

  assign BUSY     = (r_state != S_IDLE);
  assign DONE     = (r_state == S_FIN);
  assign LD_READY = (r_state == S_LOAD);
  assign W_VALID  = (r_occ != 2'd0);
  assign W_DATA   = r_fifo_data[r_rd_ptr];
  assign W_LAST   = W_VALID && r_fifo_last[r_rd_ptr];

endmodule

// File: tb/tb_weight_bram_sequencer.sv
// tb/tb_weight_bram_sequencer.sv - directed bench for weight_bram_sequencer
// Negedge read-first BRAM model; checks LOAD, READ timing, stalls, abort and ignored inputs.
module tb_weight_bram_sequencer;
  localparam int DEPTH = 28;
  localparam int AW    = 5;
  localparam int DW    = 16;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          START;
  logic          MODE;
  logic          BUSY;
  logic          DONE;
  logic [DW-1:0] LD_DATA;
  logic          LD_VALID;
  logic          LD_READY;
  logic [DW-1:0] W_DATA;
  logic          W_VALID;
  logic          W_READY;
  logic          W_LAST;
  logic [AW-1:0] BRAM_ADDR;
  logic          BRAM_EN;
  logic          BRAM_WE;
  logic [DW-1:0] BRAM_DI;
  logic [DW-1:0] BRAM_DO;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  weight_bram_sequencer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .MODE(MODE),
    .BUSY(BUSY), .DONE(DONE),
    .LD_DATA(LD_DATA), .LD_VALID(LD_VALID), .LD_READY(LD_READY),
    .W_DATA(W_DATA), .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_EN(BRAM_EN), .BRAM_WE(BRAM_WE),
    .BRAM_DI(BRAM_DI), .BRAM_DO(BRAM_DO)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BRAM_EN) begin
      BRAM_DO <= mem[BRAM_ADDR];
      if (BRAM_WE) mem[BRAM_ADDR] <= BRAM_DI;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {20'd0, BRAM_ADDR, BUSY, DONE, LD_READY, W_VALID, W_LAST, BRAM_EN, BRAM_WE}, 32'd0);
    check({tag, "_data"}, {W_DATA, BRAM_DI}, 32'd0);
  endtask

  // mode 0: W_READY high; 1: W_READY pattern 1,0,0,1; 2: W_READY high plus stray START/LD_VALID
  task automatic run_read(input logic [15:0] base, input int mode, input int abort_at, input int exp_done);
    int idx, rd_idx, done_cyc, first_valid;
    logic stalled, hs;
    logic [DW-1:0] held_data;
    START = 1'b1; MODE = 1'b0;
    tick();
    START = 1'b0;
    idx = 0; rd_idx = 0; done_cyc = 0; first_valid = 0; stalled = 1'b0; held_data = '0;
    for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
      W_READY = (mode == 1) ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      if (mode == 2) begin
        LD_VALID = 1'b1;
        MODE     = 1'b1;
        START    = (cyc == 8);
        check("rd_ld_ready", LD_READY, 0);
      end
      if (DONE) done_cyc = cyc;
      if (stalled) begin
        check("stall_valid", W_VALID, 1);
        check("stall_data", W_DATA, held_data);
      end
      if (W_VALID) begin
        if (first_valid == 0) first_valid = cyc;
        check("rd_data", W_DATA, base + idx);
        check("rd_last", W_LAST, idx == DEPTH - 1);
      end else begin
        check("rd_last_idle", W_LAST, 0);
      end
      hs        = W_VALID && W_READY;
      stalled   = W_VALID && !W_READY;
      held_data = W_DATA;
      tick();
      if (hs) idx++;
      if (BRAM_EN) begin
        check("rd_addr", BRAM_ADDR, rd_idx);
        check("rd_we", BRAM_WE, 0);
        rd_idx++;
      end
      if (abort_at != 0 && idx == abort_at) begin
        #1 RST_N = 1'b0;
        #1 check_zero("mid_reset");
        check("mid_reset_no_done", done_cyc, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
          tick();
          check("post_abort_done", DONE, 0);
          check("post_abort_busy", BUSY, 0);
        end
        return;
      end
    end
    START = 1'b0; MODE = 1'b0; LD_VALID = 1'b0;
    check("rd_done_seen", done_cyc != 0, 1);
    check("rd_words", idx, DEPTH);
    check("rd_reads", rd_idx, DEPTH);
    check("rd_done_pulse", DONE, 0);
    check("rd_busy_end", BUSY, 0);
    if (exp_done != 0) begin
      check("rd_first_valid", first_valid, 3);
      check("rd_done_cyc", done_cyc, exp_done);
    end
  endtask

  initial begin
    int done_cyc, n_beats, wr_idx;
    logic consumed;
    START = 1'b0; MODE = 1'b0; LD_DATA = '0; LD_VALID = 1'b0; W_READY = 1'b0;
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    #2 check_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    check("idle_busy", BUSY, 0);
    check("idle_ld_ready", LD_READY, 0);

    // LOAD 0x0100+i with LD_VALID held high
    START = 1'b1; MODE = 1'b1; LD_VALID = 1'b1; LD_DATA = 16'h0100;
    tick();
    START = 1'b0;
    check("ld_busy", BUSY, 1);
    done_cyc = 0; n_beats = 0; wr_idx = 0;
    for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
      if (DONE) done_cyc = cyc;
      LD_DATA  = 16'h0100 + n_beats[15:0];
      consumed = LD_READY && LD_VALID;
      tick();
      if (consumed) n_beats++;
      if (BRAM_EN) begin
        check("ld_we", BRAM_WE, 1);
        check("ld_addr", BRAM_ADDR, wr_idx);
        check("ld_di", BRAM_DI, 16'h0100 + wr_idx);
        wr_idx++;
      end
    end
    check("ld_done_cyc", done_cyc, 29);
    check("ld_writes", wr_idx, DEPTH);
    check("ld_beats", n_beats, DEPTH);
    check("ld_ready_after", LD_READY, 0);
    check("ld_busy_after", BUSY, 0);
    tick();
    check("ld_ready_idle", LD_READY, 0);
    check("ld_no_extra_wr", BRAM_EN, 0);
    LD_VALID = 1'b0;

    run_read(16'h0100, 0, 5, 0);
    run_read(16'h0100, 0, 0, 31);
    run_read(16'h0100, 1, 0, 0);
    run_read(16'h0100, 2, 0, 31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
